// File: rtl/debounce_scheduler.sv
// Front-panel button debouncer: one shared prescaler scans NUM_BTN synchronized buttons
// round-robin and queues debounced presses as events over a valid/ready handshake.
module debounce_scheduler #(
    parameter int NUM_BTN    = 4,
    parameter int TICK_DIV   = 250000,
    parameter int STABLE_CNT = 4,
    localparam int IW = $clog2(NUM_BTN),
    localparam int PW = $clog2(TICK_DIV),
    localparam int CW = $clog2(STABLE_CNT + 1)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic [NUM_BTN-1:0] i_btn_raw,
    output logic [NUM_BTN-1:0] o_btn_level,
    output logic [NUM_BTN-1:0] o_btn_press,
    output logic               o_scan_tick,
    output logic [IW-1:0]      o_scan_idx,
    output logic               o_evt_valid,
    output logic [IW-1:0]      o_evt_id,
    input  logic               i_evt_ready,
    output logic               o_evt_overflow
);

    logic [NUM_BTN-1:0] r_sync1, r_sync2, r_level, r_press, r_pending;
    logic [PW-1:0]      r_presc;
    logic [IW-1:0]      r_scan_idx, r_ptr;
    logic [CW-1:0]      r_cnt [NUM_BTN];
    logic               r_ovf;

    logic               w_tick, w_sync_c, w_lvl_c, w_found, w_hit, w_valid, w_xfer, w_ovf_evt;
    logic [NUM_BTN-1:0] w_level_nxt, w_set, w_clr, w_pend_nxt;
    logic [CW-1:0]      w_cnt_nxt [NUM_BTN];
    logic [CW-1:0]      w_cnt_c;
    logic [IW-1:0]      w_evt_id, w_cand, w_ptr_nxt, w_idx_nxt;

    assign w_tick    = i_enable & (r_presc == PW'(TICK_DIV - 1));
    assign w_idx_nxt = (r_scan_idx == IW'(NUM_BTN - 1)) ? {IW{1'b0}} : r_scan_idx + IW'(1);

    // Two-flop synchronizer, runs regardless of enable
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_sync1 <= {NUM_BTN{1'b0}};
            r_sync2 <= {NUM_BTN{1'b0}};
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Prescaler and scan pointer; both freeze while enable is low
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_presc    <= {PW{1'b0}};
            r_scan_idx <= {IW{1'b0}};
        end else if (i_enable) begin
            r_presc    <= w_tick ? {PW{1'b0}} : r_presc + PW'(1);
            r_scan_idx <= w_tick ? w_idx_nxt : r_scan_idx;
        end else begin
            r_presc    <= r_presc;
            r_scan_idx <= r_scan_idx;
        end
    end

    // Stability counter of the scanned channel; a level flip to 1 raises a press
    always_comb begin
        w_level_nxt = r_level;
        w_cnt_nxt   = r_cnt;
        w_set       = {NUM_BTN{1'b0}};
        w_sync_c    = r_sync2[r_scan_idx];
        w_lvl_c     = r_level[r_scan_idx];
        w_cnt_c     = r_cnt[r_scan_idx];
        if (w_tick) begin
            if (w_sync_c == w_lvl_c) begin
                w_cnt_nxt[r_scan_idx] = {CW{1'b0}};
            end else if (w_cnt_c == CW'(STABLE_CNT - 1)) begin
                w_level_nxt[r_scan_idx] = w_sync_c;
                w_cnt_nxt[r_scan_idx]   = {CW{1'b0}};
                w_set[r_scan_idx]       = w_sync_c;
            end else begin
                w_cnt_nxt[r_scan_idx] = w_cnt_c + CW'(1);
            end
        end else begin
            w_set = {NUM_BTN{1'b0}};
        end
    end

    // Round-robin pick: first pending channel at or after the pointer
    always_comb begin
        w_evt_id = {IW{1'b0}};
        w_found  = 1'b0;
        w_hit    = 1'b0;
        w_cand   = {IW{1'b0}};
        for (int k = 0; k < NUM_BTN; k++) begin
            w_cand   = IW'((32'(r_ptr) + 32'(k)) % 32'(NUM_BTN));
            w_hit    = ~w_found & r_pending[w_cand];
            w_evt_id = w_hit ? w_cand : w_evt_id;
            w_found  = w_found | w_hit;
        end
    end

    // A press landing on the channel being transferred wins and is not an overflow
    assign w_valid    = |r_pending;
    assign w_xfer     = w_valid & i_evt_ready;
    assign w_clr      = w_xfer ? ({{(NUM_BTN-1){1'b0}}, 1'b1} << w_evt_id) : {NUM_BTN{1'b0}};
    assign w_pend_nxt = (r_pending & ~w_clr) | w_set;
    assign w_ovf_evt  = |(w_set & r_pending & ~w_clr);
    assign w_ptr_nxt  = (w_evt_id == IW'(NUM_BTN - 1)) ? {IW{1'b0}} : w_evt_id + IW'(1);

    // Debounce state, press pulses, pending events and fairness pointer
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_level   <= {NUM_BTN{1'b0}};
            r_press   <= {NUM_BTN{1'b0}};
            r_pending <= {NUM_BTN{1'b0}};
            r_ptr     <= {IW{1'b0}};
            r_ovf     <= 1'b0;
            for (int k = 0; k < NUM_BTN; k++) begin
                r_cnt[k] <= {CW{1'b0}};
            end
        end else begin
            r_level   <= w_level_nxt;
            r_press   <= w_set;
            r_pending <= w_pend_nxt;
            r_ptr     <= w_xfer ? w_ptr_nxt : r_ptr;
            r_ovf     <= r_ovf | w_ovf_evt;
            for (int k = 0; k < NUM_BTN; k++) begin
                r_cnt[k] <= w_cnt_nxt[k];
            end
        end
    end

    assign o_btn_level    = r_level;
    assign o_btn_press    = r_press;
    assign o_scan_tick    = w_tick;
    assign o_scan_idx     = r_scan_idx;
    assign o_evt_valid    = w_valid;
    assign o_evt_id       = w_evt_id;
    assign o_evt_overflow = r_ovf;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Bench for debounce_scheduler: vector table, directed corner sequences and random
// stimulus, all checked every cycle against a behavioural model of the panel.
module tb_debounce_scheduler;
    localparam int N  = 4;
    localparam int TD = 4;
    localparam int SC = 3;

    logic       clk = 1'b0;
    logic       rst, en, ready;
    logic [3:0] raw;
    logic [3:0] level, press;
    logic       tick, valid, ovf;
    logic [1:0] idx, id;

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model state
    logic [3:0] m_s1, m_s2, m_level, m_press, m_pend;
    int         m_presc, m_idx, m_ptr;
    int         m_cnt [4];
    logic       m_ovf;

    typedef struct {
        logic       en;
        logic       t;
        logic [1:0] i;
    } vec_t;
    vec_t tbl [31];

    always #5 clk = ~clk;

    debounce_scheduler #(.NUM_BTN(N), .TICK_DIV(TD), .STABLE_CNT(SC)) dut (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_btn_raw(raw),
        .o_btn_level(level), .o_btn_press(press), .o_scan_tick(tick), .o_scan_idx(idx),
        .o_evt_valid(valid), .o_evt_id(id), .i_evt_ready(ready), .o_evt_overflow(ovf)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic m_reset();
        m_s1 = 4'h0; m_s2 = 4'h0; m_level = 4'h0; m_press = 4'h0; m_pend = 4'h0;
        m_presc = 0; m_idx = 0; m_ptr = 0; m_ovf = 1'b0;
        for (int k = 0; k < N; k++) m_cnt[k] = 0;
    endtask

    function automatic logic m_tick();
        return en && (m_presc == TD - 1);
    endfunction

    function automatic int m_id();
        for (int k = 0; k < N; k++)
            if (m_pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return 0;
    endfunction

    // one clock edge of the panel, from the rules: sample, debounce, queue, hand off
    task automatic m_edge();
        logic [3:0] set_m, clr_m;
        logic       t, v;
        int         c, sel;
        t = m_tick(); v = |m_pend; sel = m_id();
        set_m = 4'h0; clr_m = 4'h0;
        if (t) begin
            c = m_idx;
            if (m_s2[c] != m_level[c]) begin
                m_cnt[c]++;
                if (m_cnt[c] == SC) begin
                    m_level[c] = m_s2[c];
                    m_cnt[c]   = 0;
                    if (m_level[c]) set_m[c] = 1'b1;
                end
            end else m_cnt[c] = 0;
            m_idx = (m_idx + 1) % N;
        end
        if (v && ready) clr_m[sel] = 1'b1;
        if ((set_m & m_pend & ~clr_m) != 4'h0) m_ovf = 1'b1;
        m_pend  = (m_pend & ~clr_m) | set_m;
        if (v && ready) m_ptr = (sel + 1) % N;
        m_press = set_m;
        if (en) m_presc = t ? 0 : m_presc + 1;
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic settle();
        logic [14:0] act, exp;
        #1;
        exp = {m_level, m_press, m_tick(), 2'(m_idx), |m_pend, 2'(m_id()), m_ovf};
        act = {level, press, tick, idx, valid, id, ovf};
        chk("model", 32'(act), 32'(exp));
    endtask

    task automatic tick_edge();
        @(posedge clk);
        if (!rst) m_reset(); else m_edge();
        @(negedge clk);
    endtask

    task automatic cyc();
        settle();
        tick_edge();
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        m_reset();
        settle();
        chk("reset_valid", 32'(valid), 32'd0);
        tick_edge();
        rst = 1'b1;
    endtask

    // stop right after the edge that scans channel ch
    task automatic wait_scan(input int ch);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            settle();
            if (tick && idx == 2'(ch)) begin
                found = 1'b1;
                break;
            end
            tick_edge();
        end
        chk("scan_found", 32'(found), 32'd1);
        tick_edge();
    endtask

    task automatic collect(input int n, output int q[$]);
        q = {};
        for (int k = 0; k < n; k++) begin
            settle();
            if (valid && ready) q.push_back(int'(id));
            tick_edge();
        end
    endtask

    initial begin
        int acc[$];
        int np, nv, nt, nscan;
        logic seen_v;
        logic [1:0] seen_id;

        for (int k = 0; k < 20; k++) begin
            tbl[k].en = 1'b1;
            tbl[k].t  = (k % 4 == 3);
            tbl[k].i  = 2'((k / 4) % 4);
        end
        tbl[20] = '{1'b1, 1'b0, 2'd1}; tbl[21] = '{1'b1, 1'b0, 2'd1};
        tbl[22] = '{1'b0, 1'b0, 2'd1}; tbl[23] = '{1'b0, 1'b0, 2'd1};
        tbl[24] = '{1'b1, 1'b0, 2'd1}; tbl[25] = '{1'b1, 1'b1, 2'd1};
        tbl[26] = '{1'b1, 1'b0, 2'd2}; tbl[27] = '{1'b1, 1'b0, 2'd2};
        tbl[28] = '{1'b1, 1'b0, 2'd2}; tbl[29] = '{1'b0, 1'b0, 2'd2};
        tbl[30] = '{1'b1, 1'b1, 2'd2};

        rst = 1'b0; en = 1'b1; ready = 1'b1; raw = 4'hF;
        m_reset();
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("reset_outputs", 32'({level, press, tick, idx, valid, id, ovf}), 32'd0);
            tick_edge();
        end
        raw = 4'h0;
        rst = 1'b1;

        // prescaler / scan sequencing, including enable freezes
        for (int k = 0; k < 31; k++) begin
            en = tbl[k].en;
            settle();
            chk("tbl_tick", 32'(tick), 32'(tbl[k].t));
            chk("tbl_idx", 32'(idx), 32'(tbl[k].i));
            chk("tbl_valid", 32'(valid), 32'd0);
            tick_edge();
        end
        en = 1'b1;

        // clean press on channel 2
        raw[2] = 1'b1; np = 0; seen_v = 1'b0; seen_id = 2'd0;
        for (int k = 0; k < 120; k++) begin
            settle();
            if (press[2]) np++;
            if (valid) begin seen_v = 1'b1; seen_id = id; end
            tick_edge();
        end
        chk("clean_presses", 32'(np), 32'd1);
        chk("clean_valid", 32'(seen_v), 32'd1);
        chk("clean_id", 32'(seen_id), 32'd2);
        chk("clean_level", 32'(level[2]), 32'd1);
        raw[2] = 1'b0;
        run(80);
        chk("release_level", 32'(level[2]), 32'd0);

        // bounce on channel 1: agrees with level every second scan
        wait_scan(1);
        np = 0; nv = 0;
        for (int r = 0; r < 8; r++) begin
            raw[1] = (r % 2 == 0);
            for (int k = 0; k < 16; k++) begin
                settle();
                if (press[1]) np++;
                if (valid) nv++;
                tick_edge();
            end
        end
        chk("bounce_level", 32'(level[1]), 32'd0);
        chk("bounce_presses", 32'(np), 32'd0);
        chk("bounce_events", 32'(nv), 32'd0);
        raw[1] = 1'b1; np = 0;
        for (int k = 0; k < 70; k++) begin
            settle();
            if (press[1]) np++;
            tick_edge();
        end
        chk("hold_presses", 32'(np), 32'd1);
        raw[1] = 1'b0;
        run(70);

        // arbitration from pointer 0
        do_reset();
        ready = 1'b0; raw = 4'b1011;
        run(80);
        settle();
        chk("arb_valid", 32'(valid), 32'd1);
        chk("arb_first", 32'(id), 32'd0);
        tick_edge();
        ready = 1'b1;
        collect(6, acc);
        chk("arb_count", 32'(acc.size()), 32'd3);
        if (acc.size() == 3) begin
            chk("arb_order0", 32'(acc[0]), 32'd0);
            chk("arb_order1", 32'(acc[1]), 32'd1);
            chk("arb_order2", 32'(acc[2]), 32'd3);
        end
        chk("arb_drained", 32'(valid), 32'd0);
        raw = 4'h0;
        run(80);
        ready = 1'b0; raw = 4'b1010;
        run(80);
        ready = 1'b1;
        collect(4, acc);
        chk("arb2_count", 32'(acc.size()), 32'd2);
        if (acc.size() == 2) begin
            chk("arb2_order0", 32'(acc[0]), 32'd1);
            chk("arb2_order1", 32'(acc[1]), 32'd3);
        end
        raw = 4'h0;
        run(80);

        // overflow: second press while the first is still pending
        ready = 1'b0; raw[0] = 1'b1;
        run(80);
        chk("ovf_before", 32'(ovf), 32'd0);
        raw[0] = 1'b0;
        run(80);
        raw[0] = 1'b1;
        run(80);
        chk("ovf_set", 32'(ovf), 32'd1);
        ready = 1'b1;
        collect(4, acc);
        chk("ovf_one_event", 32'(acc.size()), 32'd1);
        chk("ovf_sticky", 32'(ovf), 32'd1);
        chk("ovf_drained", 32'(valid), 32'd0);
        raw = 4'h0;
        run(80);

        // enable low mid-debounce, then reset during a transfer
        do_reset();
        ready = 1'b0; raw[0] = 1'b1;
        run(80);
        wait_scan(2);
        raw[2] = 1'b1;
        wait_scan(2);
        en = 1'b0; ready = 1'b1; nt = 0;
        for (int k = 0; k < 40; k++) begin
            settle();
            if (tick) nt++;
            tick_edge();
        end
        chk("en_no_ticks", 32'(nt), 32'd0);
        chk("en_drain", 32'(valid), 32'd0);
        chk("en_level_held", 32'(level[2]), 32'd0);
        ready = 1'b0; en = 1'b1; nscan = 0;
        for (int k = 0; k < 100; k++) begin
            settle();
            if (level[2]) break;
            if (tick && idx == 2'd2) nscan++;
            tick_edge();
        end
        chk("en_resume_scans", 32'(nscan), 32'd2);
        chk("en_pending", 32'(valid), 32'd1);
        chk("en_pending_id", 32'(id), 32'd2);
        ready = 1'b1; rst = 1'b0;
        m_reset();
        settle();
        chk("rst_valid_drop", 32'(valid), 32'd0);
        tick_edge();
        rst = 1'b1; raw = 4'h0;
        settle();
        chk("rst_pending_gone", 32'(valid), 32'd0);
        tick_edge();

        // random stimulus against the model
        for (int k = 0; k < 3000; k++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 79) == 0) raw[b] = ~raw[b];
            ready = ($urandom_range(0, 3) != 0);
            en    = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 599) == 0) do_reset();
            else cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/debounce_scheduler.md
Name: debounce_scheduler

Overview:
- Shares one prescaled sampling tick across NUM_BTN push-button inputs for the queue-management front panel.
- Scans the buttons round-robin, one per tick, and debounces each with a per-channel stability counter.
- Queues each debounced press as a pending event and hands events one at a time to the downstream ticket/counter logic over a valid/ready interface with round-robin fairness.
- Replaces one free-running divider per button with a single prescaler plus scheduler.

Parameters:
- NUM_BTN, 4: number of button channels; legal range is 2 to 16.
- TICK_DIV, 250000: clk cycles per scan tick; must be 2 or more.
- STABLE_CNT, 4: number of consecutive differing samples of one channel needed to flip its debounced level; must be 1 or more.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low reset: low clears all state immediately; release is sampled on the next clk rising edge.
- enable  input  1  high runs the prescaler and scanning; low freezes both and holds all other state.
- btn_raw  input  NUM_BTN  raw, asynchronous, active-high buttons.
- btn_level  output  NUM_BTN  debounced level of each channel.
- btn_press  output  NUM_BTN  one-cycle pulse on a debounced rising edge.
- scan_tick  output  1  one-cycle pulse each prescaler wrap.
- scan_idx  output  clog2(NUM_BTN)  channel sampled on the current tick.
- evt_valid  output  1  at least one event is pending.
- evt_id  output  clog2(NUM_BTN)  channel of the offered event.
- evt_ready  input  1  consumer accepts the event when evt_valid is also high.
- evt_overflow  output  1  sticky flag: a press arrived on a channel that already had a pending event.

Behaviour:
- Reset values: all outputs 0; prescaler 0; scan_idx 0; all stability counters 0; pending 0; round-robin pointer 0; synchronizers 0.
- Synchronizer: each btn_raw bit passes through a 2-flop synchronizer on every clk, independent of enable. sync[i] is the second-stage flop.
- Prescaler: counts 0 to TICK_DIV-1 while enable is high. scan_tick is combinational and high while count equals TICK_DIV-1 and enable is high. On that edge the count wraps to 0.
- Scan on a tick, for channel c = scan_idx:
  - If sync[c] equals btn_level[c], clear cnt[c].
  - Otherwise, if cnt[c] equals STABLE_CNT-1, set btn_level[c] to sync[c] and clear cnt[c]; else increment cnt[c].
  - After the scan, scan_idx advances by 1 and wraps from NUM_BTN-1 to 0.
  - Counters of unscanned channels are untouched.
- Press detection: when btn_level[c] flips 0 to 1, btn_press[c] is high for exactly the cycle after the tick cycle and pending[c] sets on the same edge. A 1 to 0 flip produces no event.
- Event handshake:
  - evt_valid is combinational: the OR of all pending bits.
  - evt_id is the first pending channel at or after the round-robin pointer, wrapping.
  - evt_id is stable while evt_valid is high and evt_ready is low, unless a higher-priority channel becomes pending. Consumers must sample evt_id only on the accepting cycle.
  - Transfer occurs when evt_valid and evt_ready are both high: pending[evt_id] clears and the pointer moves to evt_id+1, with wrap.
  - evt_ready is ignored while evt_valid is low.
- Simultaneous events:
  - Press-set and transfer-clear on the same channel in the same cycle: the set wins, pending stays 1, and evt_overflow is not set.
  - Press on a channel that is already pending with no transfer that cycle: pending stays 1 and evt_overflow sets. evt_overflow clears only on reset.
- enable low:
  - No ticks, no scans, no new presses.
  - The handshake still drains pending events.
  - The prescaler count is held, not cleared.
- Reset mid-operation: all state clears asynchronously; in-flight pending events are discarded.

Test Plan:
- All tests use NUM_BTN=4, TICK_DIV=4, STABLE_CNT=3, evt_ready=1, and enable=1 unless stated. Each channel is therefore scanned every 16 clk.
- Reset check: hold reset low for 5 cycles with btn_raw=4'hF -> all outputs 0; after release, scan_tick first pulses on clk 4 and scan_idx sequences 0,1,2,3,0.
- Clean press: raise btn_raw[2] and hold -> btn_level[2] rises on the third scan of channel 2 after sync; btn_press[2] pulses once; evt_valid pulses with evt_id=2.
- Bounce rejection: toggle btn_raw[1] so that it agrees with the stable level on every second scan of channel 1 -> btn_level[1] stays 0 and no event is produced. Then hold it for 3 scans -> exactly one press.
- Arbitration: set evt_ready=0 and press channels 0, 1 and 3 -> evt_valid=1 with evt_id=0. Then evt_ready=1 -> accepted ids are 0, 1, 3, followed by evt_valid=0. Next press 1 and 3 with the pointer at 0 -> order 1, 3.
- Overflow: set evt_ready=0, press channel 0, release for 3 scans, press again -> evt_overflow=1, exactly one pending event, and the flag stays set after the drain.
- Enable and reset: drop enable mid-debounce with cnt[2]=1 -> no scan_tick, counter held, events still drain; raise enable -> debounce resumes from 1. Assert reset mid-transfer -> evt_valid drops immediately and pending clears.
